// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable clock divider:
//   mode_e  - channel output mode (toggle = 50% square wave, pulse = strobe)
//   chw()   - width of the channel-select field for a given channel count
// ---------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // A single channel still needs a 1-bit select so the port never
    // collapses to zero width.
    function automatic int chw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// ---------------------------------------------------------------------------
// clk_div_chan
// One channel of the programmable divider: period counter, active and
// pending divisor/mode registers, and the registered outputs.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   en_i             run enable for this channel
//   sync_i           phase-align request shared by all channels
//   acc_i            a config request for this channel was accepted
//   div_i, mode_i    divisor / mode carried by that request
//   pend_valid_o     a config is waiting for the next period boundary
//   clk_out_o        divided clock (toggle) or strobe (pulse), registered
//   tick_o           one-cycle strobe on every period wrap, registered
// ---------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH   = 18,
    parameter int DEF_DIV = 131071
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             acc_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             mode_i,
    output logic             pend_valid_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] divAct_q,  divAct_d;
    mode_e            modeAct_q, modeAct_d;
    logic [WIDTH-1:0] pendDiv_q, pendDiv_d;
    mode_e            pendMode_q, pendMode_d;
    logic             pendValid_q, pendValid_d;
    logic             clkOut_q,  clkOut_d;
    logic             tick_q,    tick_d;

    logic             wrap;
    logic             boundary;

    // Next-state logic. sync and a disabled channel both park the counter
    // at zero with outputs low; they count as period boundaries, so a
    // pending config is taken there as well as at a normal wrap. The wrap
    // cycle's own output is decided by the mode that was active before it.
    // Acceptance is evaluated last: the top only accepts when nothing is
    // pending, so a request landing on a boundary cycle simply becomes the
    // new pending value and waits for the following boundary.
    always_comb begin
        cnt_d       = cnt_q;
        divAct_d    = divAct_q;
        modeAct_d   = modeAct_q;
        pendDiv_d   = pendDiv_q;
        pendMode_d  = pendMode_q;
        pendValid_d = pendValid_q;
        clkOut_d    = clkOut_q;
        tick_d      = 1'b0;
        boundary    = 1'b0;

        wrap = (cnt_q == divAct_q);

        if (sync_i || !en_i) begin
            cnt_d    = '0;
            clkOut_d = 1'b0;
            tick_d   = 1'b0;
            boundary = 1'b1;
        end else if (wrap) begin
            cnt_d    = '0;
            tick_d   = 1'b1;
            clkOut_d = (modeAct_q == MODE_PULSE) ? 1'b1 : ~clkOut_q;
            boundary = 1'b1;
        end else begin
            cnt_d  = cnt_q + WIDTH'(1);
            tick_d = 1'b0;
            if (modeAct_q == MODE_PULSE) begin
                clkOut_d = 1'b0;
            end
        end

        if (boundary && pendValid_q) begin
            divAct_d    = pendDiv_q;
            modeAct_d   = pendMode_q;
            pendValid_d = 1'b0;
        end

        if (acc_i) begin
            pendDiv_d   = div_i;
            pendMode_d  = mode_e'(mode_i);
            pendValid_d = 1'b1;
        end
    end

    // State registers; reset discards any pending config.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            divAct_q    <= WIDTH'(DEF_DIV);
            modeAct_q   <= MODE_TOGGLE;
            pendDiv_q   <= '0;
            pendMode_q  <= MODE_TOGGLE;
            pendValid_q <= 1'b0;
            clkOut_q    <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            divAct_q    <= divAct_d;
            modeAct_q   <= modeAct_d;
            pendDiv_q   <= pendDiv_d;
            pendMode_q  <= pendMode_d;
            pendValid_q <= pendValid_d;
            clkOut_q    <= clkOut_d;
            tick_q      <= tick_d;
        end
    end

    assign pend_valid_o = pendValid_q;
    assign clk_out_o    = clkOut_q;
    assign tick_o       = tick_q;

endmodule

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
// Multi-channel programmable clock divider / tick generator. Each channel
// runs from its own runtime-loadable divisor D and mode; new settings are
// taken only at a period boundary so outputs never glitch.
//   toggle mode: clk_out period 2*(D+1), 50% duty, tick on each toggle
//   pulse mode : clk_out = tick, one-cycle strobe every D+1 cycles
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   en[NCH]            per-channel run enable
//   sync               restart all channels in phase
//   cfg_valid/ready    config handshake (ready is combinational)
//   cfg_ch             target channel; out-of-range is accepted and flagged
//   cfg_div, cfg_mode  new divisor and mode (0 toggle, 1 pulse)
//   cfg_err            one-cycle flag for an accepted out-of-range request
//   clk_out[NCH]       divided outputs, registered
//   tick[NCH]          period-wrap strobes, registered
// ---------------------------------------------------------------------------
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int WIDTH   = 18,
    parameter int DEF_DIV = 131071
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic                 sync,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [chw(NCH)-1:0]  cfg_ch,
    input  logic [WIDTH-1:0]     cfg_div,
    input  logic                 cfg_mode,
    output logic                 cfg_err,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick
);

    localparam int CHW = chw(NCH);

    logic [NCH-1:0] pendValid;
    logic [NCH-1:0] chAccept;
    logic           selBusy;
    logic           chValid;
    logic           cfgErr_q, cfgErr_d;

    // Channel decode. A select that matches no channel leaves selBusy low,
    // so an out-of-range request is always ready and only raises cfg_err.
    always_comb begin
        selBusy  = 1'b0;
        chValid  = 1'b0;
        chAccept = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                chValid     = 1'b1;
                selBusy     = pendValid[i];
                chAccept[i] = cfg_valid && !pendValid[i];
            end
        end
        cfgErr_d = cfg_valid && !chValid;
    end

    assign cfg_ready = !selBusy;

    // Error flag lasts exactly one cycle per offending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfgErr_q <= 1'b0;
        end else begin
            cfgErr_q <= cfgErr_d;
        end
    end

    assign cfg_err = cfgErr_q;

    for (genvar g = 0; g < NCH; g++) begin : gChan
        clk_div_chan #(
            .WIDTH   (WIDTH),
            .DEF_DIV (DEF_DIV)
        ) uChan (
            .clk          (clk),
            .rst          (rst),
            .en_i         (en[g]),
            .sync_i       (sync),
            .acc_i        (chAccept[g]),
            .div_i        (cfg_div),
            .mode_i       (cfg_mode),
            .pend_valid_o (pendValid[g]),
            .clk_out_o    (clk_out[g]),
            .tick_o       (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
// Directed bench for clk_div_prog with NCH=3, WIDTH=4, DEF_DIV=3. Each
// vector drives the inputs for one clock, and after the edge the
// registered outputs plus cfg_ready/cfg_err are compared with
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int NCH     = 3;
    localparam int WIDTH   = 4;
    localparam int DEF_DIV = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en;
    logic             sync;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_mode;
    logic             cfg_err;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    clk_div_prog #(
        .NCH     (NCH),
        .WIDTH   (WIDTH),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    typedef struct {
        logic       rst;
        logic [2:0] en;
        logic       sync;
        logic       cv;
        logic [1:0] ch;
        logic [3:0] div;
        logic       mode;
        logic [2:0] eClk;
        logic [2:0] eTick;
        logic       eRdy;
        logic       eErr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [2:0] e, input logic s,
                                input logic v, input logic [1:0] c, input logic [3:0] d,
                                input logic m, input logic [2:0] ec, input logic [2:0] et,
                                input logic er, input logic ee);
        vec_t x;
        x.rst = r;  x.en = e;   x.sync = s;  x.cv = v;    x.ch = c;
        x.div = d;  x.mode = m; x.eClk = ec; x.eTick = et;
        x.eRdy = er; x.eErr = ee;
        return x;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        en        = v.en;
        sync      = v.sync;
        cfg_valid = v.cv;
        cfg_ch    = v.ch;
        cfg_div   = v.div;
        cfg_mode  = v.mode;
    endtask

    task automatic cmp(input string name, input logic [2:0] act, input logic [2:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        cmp({name, ".clk_out"},   clk_out,            v.eClk);
        cmp({name, ".tick"},      tick,               v.eTick);
        cmp({name, ".cfg_ready"}, {2'b00, cfg_ready}, {2'b00, v.eRdy});
        cmp({name, ".cfg_err"},   {2'b00, cfg_err},   {2'b00, v.eErr});
    endtask

    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(v, name);
    endtask

    // Safety net in case the bench ever stops advancing.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Fields: rst, en, sync, cfg_valid, cfg_ch, cfg_div, cfg_mode,
        //         expected clk_out, tick, cfg_ready, cfg_err.
        // Reset, then ch0 alone at the default D=3 in toggle mode.
        tbl.push_back(mk(1, 3'b000, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0));
        tbl.push_back(mk(1, 3'b000, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b001, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b001, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b001, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b001, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b001, 3'b001, 1, 0));
        // Mid-period write of D=1 pulse to ch0: last toggle at the wrap,
        // then a strobe every 2 cycles.
        tbl.push_back(mk(0, 3'b001, 0, 1, 2'd0, 4'd1, 1, 3'b001, 3'b000, 0, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b001, 3'b000, 0, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b001, 3'b000, 0, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b001, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 0, 0, 2'd0, 4'd0, 0, 3'b001, 3'b001, 1, 0));

        applyStimulus(tbl[0]);
        for (int i = 0; i < tbl.size(); i++) begin
            runVec(tbl[i], $sformatf("basic[%0d]", i));
        end

        // ch1: D=0 toggle loaded while disabled, then D=0 pulse while running.
        runVec(mk(0, 3'b000, 0, 1, 2'd1, 4'd0, 0, 3'b000, 3'b000, 0, 0), "d0.load");
        runVec(mk(0, 3'b000, 0, 0, 2'd1, 4'd0, 0, 3'b000, 3'b000, 1, 0), "d0.apply");
        runVec(mk(0, 3'b010, 0, 0, 2'd1, 4'd0, 0, 3'b010, 3'b010, 1, 0), "d0.tog1");
        runVec(mk(0, 3'b010, 0, 0, 2'd1, 4'd0, 0, 3'b000, 3'b010, 1, 0), "d0.tog2");
        runVec(mk(0, 3'b010, 0, 0, 2'd1, 4'd0, 0, 3'b010, 3'b010, 1, 0), "d0.tog3");
        runVec(mk(0, 3'b010, 0, 0, 2'd1, 4'd0, 0, 3'b000, 3'b010, 1, 0), "d0.tog4");
        runVec(mk(0, 3'b010, 0, 1, 2'd1, 4'd0, 1, 3'b010, 3'b010, 0, 0), "d0.wrpulse");
        runVec(mk(0, 3'b010, 0, 0, 2'd1, 4'd0, 0, 3'b000, 3'b010, 1, 0), "d0.lasttog");
        for (int i = 0; i < 3; i++) begin
            runVec(mk(0, 3'b010, 0, 0, 2'd1, 4'd0, 0, 3'b010, 3'b010, 1, 0),
                   $sformatf("d0.held[%0d]", i));
        end

        // ch2: back-to-back writes; the second one stalls until the wrap.
        runVec(mk(0, 3'b100, 0, 1, 2'd2, 4'd2, 0, 3'b000, 3'b000, 0, 0), "b2b.first");
        runVec(mk(0, 3'b100, 0, 1, 2'd2, 4'd1, 1, 3'b000, 3'b000, 0, 0), "b2b.stall1");
        runVec(mk(0, 3'b100, 0, 1, 2'd2, 4'd1, 1, 3'b000, 3'b000, 0, 0), "b2b.stall2");
        runVec(mk(0, 3'b100, 0, 1, 2'd2, 4'd1, 1, 3'b100, 3'b100, 1, 0), "b2b.wrap1");
        runVec(mk(0, 3'b100, 0, 1, 2'd2, 4'd1, 1, 3'b100, 3'b000, 0, 0), "b2b.accept2");
        runVec(mk(0, 3'b100, 0, 0, 2'd2, 4'd0, 0, 3'b100, 3'b000, 0, 0), "b2b.count");
        runVec(mk(0, 3'b100, 0, 0, 2'd2, 4'd0, 0, 3'b000, 3'b100, 1, 0), "b2b.wrap2");
        runVec(mk(0, 3'b100, 0, 0, 2'd2, 4'd0, 0, 3'b000, 3'b000, 1, 0), "b2b.p0");
        runVec(mk(0, 3'b100, 0, 0, 2'd2, 4'd0, 0, 3'b100, 3'b100, 1, 0), "b2b.p1");
        runVec(mk(0, 3'b100, 0, 0, 2'd2, 4'd0, 0, 3'b000, 3'b000, 1, 0), "b2b.p2");
        runVec(mk(0, 3'b100, 0, 0, 2'd2, 4'd0, 0, 3'b100, 3'b100, 1, 0), "b2b.p3");

        // Out-of-range channel: accepted at once, one-cycle error flag.
        runVec(mk(0, 3'b100, 0, 1, 2'd3, 4'd5, 0, 3'b000, 3'b000, 1, 1), "badch.req");
        runVec(mk(0, 3'b100, 0, 0, 2'd2, 4'd0, 0, 3'b100, 3'b100, 1, 0), "badch.after");

        // Reload all channels with D=3 toggle while disabled, stagger them,
        // park a pending D=1 on ch1, then sync.
        runVec(mk(0, 3'b000, 0, 1, 2'd0, 4'd3, 0, 3'b000, 3'b000, 0, 0), "sync.ld0");
        runVec(mk(0, 3'b000, 0, 1, 2'd1, 4'd3, 0, 3'b000, 3'b000, 0, 0), "sync.ld1");
        runVec(mk(0, 3'b000, 0, 1, 2'd2, 4'd3, 0, 3'b000, 3'b000, 0, 0), "sync.ld2");
        runVec(mk(0, 3'b000, 0, 0, 2'd2, 4'd0, 0, 3'b000, 3'b000, 1, 0), "sync.ap2");
        runVec(mk(0, 3'b001, 0, 0, 2'd2, 4'd0, 0, 3'b000, 3'b000, 1, 0), "sync.st0");
        runVec(mk(0, 3'b011, 0, 0, 2'd2, 4'd0, 0, 3'b000, 3'b000, 1, 0), "sync.st1");
        runVec(mk(0, 3'b111, 0, 0, 2'd2, 4'd0, 0, 3'b000, 3'b000, 1, 0), "sync.st2");
        runVec(mk(0, 3'b111, 0, 1, 2'd1, 4'd1, 0, 3'b001, 3'b001, 0, 0), "sync.pend");
        runVec(mk(0, 3'b111, 1, 0, 2'd1, 4'd0, 0, 3'b000, 3'b000, 1, 0), "sync.pulse");
        runVec(mk(0, 3'b111, 0, 0, 2'd1, 4'd0, 0, 3'b000, 3'b000, 1, 0), "sync.a1");
        runVec(mk(0, 3'b111, 0, 0, 2'd1, 4'd0, 0, 3'b010, 3'b010, 1, 0), "sync.a2");
        runVec(mk(0, 3'b111, 0, 0, 2'd1, 4'd0, 0, 3'b010, 3'b000, 1, 0), "sync.a3");
        runVec(mk(0, 3'b111, 0, 0, 2'd1, 4'd0, 0, 3'b101, 3'b111, 1, 0), "sync.a4");
        runVec(mk(0, 3'b111, 0, 0, 2'd1, 4'd0, 0, 3'b101, 3'b000, 1, 0), "sync.a5");

        // Reset mid-period with a pending write on ch0 that must be dropped.
        runVec(mk(0, 3'b111, 0, 1, 2'd0, 4'd1, 1, 3'b111, 3'b010, 0, 0), "rst.pend");
        runVec(mk(1, 3'b111, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0), "rst.hit");
        for (int i = 0; i < 3; i++) begin
            runVec(mk(0, 3'b111, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b000, 1, 0),
                   $sformatf("rst.cnt[%0d]", i));
        end
        runVec(mk(0, 3'b111, 0, 0, 2'd0, 4'd0, 0, 3'b111, 3'b111, 1, 0), "rst.wrap1");
        for (int i = 0; i < 3; i++) begin
            runVec(mk(0, 3'b111, 0, 0, 2'd0, 4'd0, 0, 3'b111, 3'b000, 1, 0),
                   $sformatf("rst.hi[%0d]", i));
        end
        runVec(mk(0, 3'b111, 0, 0, 2'd0, 4'd0, 0, 3'b000, 3'b111, 1, 0), "rst.wrap2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel programmable clock divider / tick generator; generalises the fixed 2^N divider.
- Each channel has a runtime-loadable divisor and mode: 50% square wave or one-cycle strobe.
- Divisor changes are glitch-free: a new setting is applied only at a period boundary.
- Sits next to the system clock and feeds slow enables to display, debounce and UART blocks.

Parameters:
- NCH, 4: number of independent channels (>=1).
- WIDTH, 18: counter/divisor width in bits.
- DEF_DIV, 131071: divisor loaded into every channel at reset. Must satisfy DEF_DIV < 2**WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  NCH  per-channel run enable.
- sync  in  1  phase-align pulse for all channels.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; combinational = !pend_valid[cfg_ch], or 1 when cfg_ch >= NCH.
- cfg_ch  in  CHW  target channel, where CHW = max(1, clog2(NCH)).
- cfg_div  in  WIDTH  new divisor D.
- cfg_mode  in  1  0 = toggle, 1 = pulse.
- cfg_err  out  1  one-cycle flag: accepted request had an invalid channel.
- clk_out  out  NCH  divided output (registered).
- tick  out  NCH  one-cycle strobe at each period wrap (registered).

Behaviour:
- Per-channel state: cnt[WIDTH], div_act, mode_act, pend_div, pend_mode, pend_valid.
- Reset:
  - cnt=0, div_act=DEF_DIV, mode_act=toggle, pend_valid=0.
  - clk_out=0, tick=0, cfg_err=0; cfg_ready therefore 1.
- Priority per cycle: rst > sync > !en > counting.
- Counting (en=1):
  - If cnt==div_act: cnt<=0 and tick<=1 ("wrap").
  - Otherwise: cnt<=cnt+1 and tick<=0.
- Output at wrap:
  - Toggle mode: clk_out<=~clk_out, giving a period of 2*(D+1) cycles at 50% duty.
  - Pulse mode: clk_out<=1 for the wrap cycle and 0 otherwise, giving a period of D+1 cycles.
- Applying pending config at a wrap:
  - If pend_valid, load div_act/mode_act from pend and clear pend_valid.
  - The wrap cycle's output follows the old mode; the new settings govern from the next cycle.
- Boundary cases:
  - D=0: toggle mode gives clk/2; pulse mode holds clk_out and tick constantly 1.
  - Enable low: cnt<=0, clk_out<=0, tick<=0. Any pending config is applied on the next cycle.
  - Enable rising: counting restarts from 0; first wrap occurs after D+1 enabled cycles.
  - sync=1: all channels get cnt<=0, clk_out<=0, tick<=0, and pending configs are applied immediately. This gives aligned phases.
- Config handshake: transfer on cfg_valid && cfg_ready.
  - Valid channel: pend_div/pend_mode <= cfg_div/cfg_mode and pend_valid<=1. cfg_ready for that channel then stays 0 until the pending value is applied.
  - cfg_ch >= NCH: request is accepted, no state changes, cfg_err<=1 for exactly one cycle.
- Simultaneous acceptance and wrap on the same channel: the new value goes to pending and is applied at the following wrap. No value is lost.
- rst mid-operation: all state returns to reset values on the next edge; pending configs are discarded.
- Counter never exceeds div_act. No overflow path exists because the comparison is ==, and div_act is always reloaded on a wrap or sync.

Decomposition:
- Package clk_div_pkg:
  - MODE_TOGGLE=1'b0, MODE_PULSE=1'b1.
  - Function chw(NCH) returning max(1, clog2(NCH)).
- Sub-module clk_div_chan holds one channel's counter, active/pending registers and output logic.
- Top instantiates NCH of them and contains the cfg decode, cfg_ready mux and cfg_err register.

Test Plan (NCH=3, WIDTH=4, DEF_DIV=3):
- Reset, then en=3'b001 -> ch0 clk_out toggles every 4 cycles (period 8) with tick high on each toggle cycle; ch1/ch2 clk_out and tick stay 0.
- Mid-period, write ch0 D=1 mode=pulse -> cfg_ready(ch0) goes 0. At the next wrap clk_out toggles one last time, then clk_out=tick pulses every 2 cycles and cfg_ready returns to 1.
- Write D=0 toggle on ch1 (en=1) -> clk_out toggles every cycle. Then write D=0 pulse -> after the next wrap, clk_out and tick are held constantly 1.
- Two back-to-back writes to ch2 while running -> second request stalls (cfg_ready=0) until ch2 wraps, then is accepted and applied at the following wrap.
- cfg_ch=3 with cfg_valid=1 -> accepted in one cycle; cfg_err=1 for exactly one cycle; all channel outputs unchanged.
- All channels running at different counts; pulse sync -> all cnt=0 and clk_out=0 next cycle, and subsequent edges align. Then assert rst mid-period -> all outputs 0 and div_act=3 with pending cleared.
